// File: rtl/serial_comparator_ctrl.sv
// Serial MSB-first magnitude comparator controller driving an external 1-bit comparator slice.
// Optional macro SERIAL_COMPARATOR_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_comparator_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a,
  output logic             cmp_b,
  output logic             cmp_e,
  input  logic             cmp_gtr,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             gtr,
  output logic             eq,
  output logic             lt,
  output logic             err
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               gtr_q, gtr_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d;
  logic               slice_one_hot;
  logic               diff_seen;

  assign slice_one_hot = (cmp_gtr ^ cmp_eq ^ cmp_lt) & ~(cmp_gtr & cmp_eq & cmp_lt);
  assign diff_seen     = gtr_q | lt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gtr_d   = gtr_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = IdxW'(WIDTH - 1);
          gtr_d   = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (!slice_one_hot) begin
          err_d   = 1'b1;
          gtr_d   = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StDone;
        end else begin
          // Only the most significant differing bit decides the result.
          if ((cmp_gtr | cmp_lt) && !diff_seen) begin
            gtr_d = cmp_gtr;
            lt_d  = cmp_lt;
          end
          if (idx_q == '0) begin
            if (cmp_eq && !diff_seen) begin
              eq_d = 1'b1;
            end
            state_d = StDone;
          end else begin
            idx_d = idx_q - 1'b1;
          end
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
          if (cmp_gtr | cmp_lt) begin
            state_d = StDone;
          end
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gtr_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gtr_q   <= gtr_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  // Slice drive comes only from registers, so it is quiet outside SCAN and during reset.
  assign cmp_e = (state_q == StScan);
  assign cmp_a = cmp_e & a_q[idx_q];
  assign cmp_b = cmp_e & b_q[idx_q];
  assign busy  = (state_q == StScan);
  assign done  = (state_q == StDone);
  assign gtr   = gtr_q;
  assign eq    = eq_q;
  assign lt    = lt_q;
  assign err   = err_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Scoreboard bench for serial_comparator_ctrl: random operands, slice fault injection, mid-scan reset.
module tb_serial_comparator_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cmp_a, cmp_b, cmp_e;
  logic         cmp_gtr, cmp_eq, cmp_lt;
  logic         busy, done, gtr, eq, lt, err;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   res;  // {gtr, eq, lt, err}
    int           n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fault_pos = 0;
  int   scan_cnt;
  int   busy_cnt = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  serial_comparator_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cmp_a   (cmp_a),
    .cmp_b   (cmp_b),
    .cmp_e   (cmp_e),
    .cmp_gtr (cmp_gtr),
    .cmp_eq  (cmp_eq),
    .cmp_lt  (cmp_lt),
    .busy    (busy),
    .done    (done),
    .gtr     (gtr),
    .eq      (eq),
    .lt      (lt),
    .err     (err)
  );

  // Number of slice evaluations completed in the current scan.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      scan_cnt <= 0;
    else if (!cmp_e) scan_cnt <= 0;
    else             scan_cnt <= scan_cnt + 1;
  end

  // Slice model with an optional forced gtr+eq fault on scanned bit number fault_pos.
  always_comb begin
    cmp_gtr = cmp_e & cmp_a & ~cmp_b;
    cmp_eq  = cmp_e & ~(cmp_a ^ cmp_b);
    cmp_lt  = cmp_e & ~cmp_a & cmp_b;
    if (cmp_e && fault_pos > 0 && scan_cnt + 1 == fault_pos) begin
      cmp_gtr = 1'b1;
      cmp_eq  = 1'b1;
      cmp_lt  = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int fault);
    exp_t e;
    int   k = -1;
    e.a = a;
    e.b = b;
    for (int i = W - 1; i >= 0; i--) if (k < 0 && a[i] != b[i]) k = i;
    if (a > b)      e.res = 4'b1000;
    else if (a < b) e.res = 4'b0010;
    else            e.res = 4'b0100;
    e.n = W;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    if (k >= 0) e.n = W - k;
`endif
    if (fault > 0 && fault <= e.n) begin
      e.res = 4'b0001;
      e.n   = fault;
    end
    return e;
  endfunction

  // Monitor: checks slice drive while busy and pops the scoreboard on every done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (exp_q.size() > 0 && scan_cnt < W)
          chk("slice_drive", {29'd0, cmp_e, cmp_a, cmp_b},
              {29'd0, 1'b1, exp_q[0].a[W-1-scan_cnt], exp_q[0].b[W-1-scan_cnt]});
      end
      if (done) begin
        chk("done_width", {31'd0, done_prev}, 32'd0);
        chk("done_quiet", {29'd0, busy, cmp_e, cmp_a | cmp_b}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", {28'd0, gtr, eq, lt, err}, {28'd0, e.res});
          chk("busy_cycles", busy_cnt, e.n);
        end
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy || done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Leaves start asserted for exactly one rising edge; returns in the first SCAN cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int fault);
    wait_idle();
    fault_pos = fault;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    exp_q.push_back(model(a, b, fault));
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    fault_pos = 0;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int fault);
    issue(a, b, fault);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {23'd0, busy, done, gtr, eq, lt, err, cmp_a, cmp_b, cmp_e}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(8'hA5, 8'h3C, 0);
    chk("a5_3c_gtr", {28'd0, gtr, eq, lt, err}, 32'b1000);
    run(8'h10, 8'h11, 0);
    chk("10_11_lt", {28'd0, gtr, eq, lt, err}, 32'b0010);

    // Equal operands, a stray start while busy, then results held while idle.
    issue(8'h5A, 8'h5A, 0);
    repeat (3) @(negedge clk);
    a_in  = 8'hFF;
    b_in  = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("eq_hold", {28'd0, gtr, eq, lt, err}, 32'b0100);
    chk("eq_hold_idle", {30'd0, busy, done}, 32'd0);

    run(8'h33, 8'h33, 3);
    chk("fault_err", {28'd0, gtr, eq, lt, err}, 32'b0001);

    // Reset in the fourth SCAN cycle aborts with no done pulse.
    issue(8'h12, 8'h12, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {23'd0, busy, done, gtr, eq, lt, err, cmp_a, cmp_b, cmp_e}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'h00, 8'hFF, 0);
    chk("post_reset_lt", {28'd0, gtr, eq, lt, err}, 32'b0010);

    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a, b;
      int           f;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      f = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W)) : 0;
      run(a, b, f);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_comparator_ctrl.md
SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to compare a_in against b_in.
REQ-005 SHALL have port a_in  input  WIDTH  operand A, unsigned; sampled only when start is accepted.
REQ-006 SHALL have port b_in  input  WIDTH  operand B, unsigned; sampled only when start is accepted.
REQ-007 SHALL have port cmp_a  output  1  bit of A presented to the external 1-bit comparator slice.
REQ-008 SHALL have port cmp_b  output  1  bit of B presented to the slice.
REQ-009 SHALL have port cmp_e  output  1  slice enable.
REQ-010 SHALL have port cmp_gtr/cmp_eq/cmp_lt  input  1 each  combinational slice results (gtr = e&A&~B, eq = e&(A~^B), lt = e&~A&B).
REQ-011 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-013 SHALL have ports gtr/eq/lt  output  1 each  registered final result, one-hot when err=0.
REQ-014 SHALL have port err  output  1  slice returned a non-one-hot result.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 IDLE: start=1 at an edge -> latch a_in/b_in, idx=WIDTH-1, clear gtr/eq/lt/err, go to SCAN; start in SCAN or DONE is ignored.
REQ-017 SCAN: cmp_e=1, cmp_a=a_reg[idx], cmp_b=b_reg[idx], driven from registers (no combinational path from start/a_in/b_in); busy=1.
REQ-018 SCAN edge, slice not one-hot (zero or multiple asserted) -> err=1, gtr/eq/lt=0, go to DONE immediately.
REQ-019 SCAN edge, cmp_gtr or cmp_lt -> record gtr or lt (first differing bit, MSB-first, decides).
REQ-020 SCAN edge, cmp_eq and idx=0 with no difference recorded -> eq=1, go to DONE.
REQ-021 SCAN edge, idx=0 -> go to DONE unconditionally; otherwise idx decrements by 1 (no wrap below 0).
REQ-022 DONE: done=1, busy=0, cmp_e=0, for exactly one cycle; then IDLE.
REQ-023 gtr/eq/lt/err SHALL hold their value from DONE until the next accepted start.
REQ-024 Outside SCAN, cmp_a=cmp_b=cmp_e=0.
REQ-025 Latency: done high in the cycle following edge start+N, N = number of bits scanned (see REQ-030/031); throughput one comparison per N+2 cycles.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force state=IDLE, idx=0, a_reg=b_reg=0.
REQ-027 rst_n=0 SHALL, asynchronously, force outputs busy, done, gtr, eq, lt, err, cmp_a, cmp_b, cmp_e to 0.
REQ-028 Reset mid-SCAN SHALL abort the comparison with no done pulse.
REQ-029 After rst_n rises, the first start edge SHALL be accepted normally.

Configuration
REQ-030 With macro SERIAL_COMPARATOR_EARLY_EXIT_EN defined: on cmp_gtr or cmp_lt, go to DONE at that edge; N = WIDTH - k, k = index of the most-significant differing bit; equal operands give N = WIDTH.
REQ-031 Without SERIAL_COMPARATOR_EARLY_EXIT_EN: always scan all WIDTH bits, N = WIDTH.
REQ-032 Without the macro, the first recorded difference SHALL be kept, and later slice results SHALL affect only err.

Verification (WIDTH=8)
REQ-033 a=8'hA5, b=8'h3C, start one cycle -> gtr=1, eq=0, lt=0; done 1 cycle after edge start+1 with EARLY_EXIT, after start+8 without.
REQ-034 a=8'h10, b=8'h11 -> lt=1; done after start+8 in both builds; busy high exactly N cycles.
REQ-035 a=b=8'h5A -> eq=1, gtr=lt=0 after 8 SCAN cycles; results held over 5 idle cycles; start re-asserted while busy -> ignored, no second done.
REQ-036 Slice model forced to cmp_eq=cmp_gtr=1 on the third scanned bit -> err=1, gtr=eq=lt=0, done after start+3.
REQ-037 rst_n pulsed low during the 4th SCAN cycle -> all outputs 0 immediately, no done; next start with a=8'h00, b=8'hFF -> lt=1.
